// File: rtl/stack_memory_pkg.sv
// Shared definitions for the processor stack store: geometry and the decoded
// strobe operation.
package stack_memory_pkg;

    localparam int STACK_DATA_WIDTH = 32;
    localparam int STACK_ADDR_WIDTH = 10;
    localparam int STACK_DEPTH      = 2 ** STACK_ADDR_WIDTH;

    // Operation selected by the active-low strobes on a given clock edge.
    typedef enum logic [1:0] {
        OP_DESELECT = 2'd0,
        OP_WRITE    = 2'd1,
        OP_READ     = 2'd2,
        OP_IDLE     = 2'd3
    } stack_op_e;

    // Decode the active-low strobes; the order of tests is the priority order:
    // chip deselect beats everything, then write beats read.
    function automatic stack_op_e decode_op(input logic ce_n,
                                            input logic oe_n,
                                            input logic we_n);
        if (ce_n)       return OP_DESELECT;
        else if (!we_n) return OP_WRITE;
        else if (!oe_n) return OP_READ;
        else            return OP_IDLE;
    endfunction

endpackage : stack_memory_pkg

// File: rtl/stack_memory_array.sv
// Plain single-port RAM: synchronous write, registered read, active-high
// strobes. The read register has a synchronous clear so the whole block still
// maps onto one block RAM with its output-register reset.
module stack_memory_array
    import stack_memory_pkg::*;
#(
    parameter int DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int ADDR_WIDTH = STACK_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // NOTE: the storage array is never reset; clearing 1024 words would need a
    // reset port the block RAM does not have. The declaration initializer only
    // sets the power-up contents, which becomes the block RAM init image.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Commit writes on the rising edge.
    always_ff @(posedge clk) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port with synchronous clear of the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule : stack_memory_array

// File: rtl/stack_memory.sv
// Processor stack store: 1024 x 32 synchronous SRAM with active-low CE/OE/WE
// strobes. Decodes the strobes with chip-select and write priority and keeps
// any access from happening on a reset edge.
module stack_memory
    import stack_memory_pkg::*;
#(
    parameter int DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int ADDR_WIDTH = STACK_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] stackData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    stack_op_e op;
    logic      mem_we;
    logic      mem_re;

    // Strobe decode; reset suppresses both the write and the read.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a signal unassigned and infers a latch.
        op     = OP_DESELECT;
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (!reset) begin
            op     = decode_op(CE, OE, WE);
            mem_we = (op == OP_WRITE);
            mem_re = (op == OP_READ);
        end
    end

    stack_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (address),
        .wdata (input_data),
        .rdata (stackData)
    );

    // The geometry is fixed by the processor's stack pointer width.
    initial assert (DEPTH == STACK_DEPTH || ADDR_WIDTH != STACK_ADDR_WIDTH);

endmodule : stack_memory

// File: tb/tb_stack_memory.sv
// Directed self-checking bench for stack_memory.
module tb_stack_memory;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          CE;
    logic          OE;
    logic          WE;
    logic [DW-1:0] input_data;
    logic [AW-1:0] address;
    logic [DW-1:0] stackData;

    int n_tests = 0;
    int n_fail  = 0;

    stack_memory dut (
        .clk        (clk),
        .reset      (reset),
        .CE         (CE),
        .OE         (OE),
        .WE         (WE),
        .input_data (input_data),
        .address    (address),
        .stackData  (stackData)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs, clock it, sample 1 time unit later.
    task automatic cycle(input logic rst, input logic ce, input logic oe,
                         input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        @(negedge clk);
        reset      = rst;
        CE         = ce;
        OE         = oe;
        WE         = we;
        address    = a;
        input_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] expected);
        n_tests++;
        assert (stackData === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, stackData, expected);
        end
    endtask

    initial begin
        reset = 1'b1; CE = 1'b1; OE = 1'b1; WE = 1'b1;
        address = '0; input_data = '0;

        // Reset for two cycles.
        cycle(1, 1, 1, 1, 10'd0, 32'h0);
        check("reset_0", 32'h0);
        cycle(1, 0, 0, 1, 10'd0, 32'h0);
        check("reset_1", 32'h0);

        // Power-up contents are zero.
        cycle(0, 0, 0, 1, 10'd0, 32'h0);
        check("powerup_rd0", 32'h0);

        // Write then read-after-write on the next cycle.
        cycle(0, 0, 1, 0, 10'd5, 32'hDEADBEEF);
        check("wr5_holds", 32'h0);
        cycle(0, 0, 0, 1, 10'd5, 32'h0);
        check("rd5", 32'hDEADBEEF);

        // Boundary addresses, then back-to-back reads each cycle.
        cycle(0, 0, 1, 0, 10'd0, 32'h00000001);
        cycle(0, 0, 1, 0, 10'd1023, 32'hFFFFFFFF);
        check("wr_bounds_hold", 32'hDEADBEEF);
        cycle(0, 0, 0, 1, 10'd0, 32'h0);
        check("rd0", 32'h00000001);
        cycle(0, 0, 0, 1, 10'd1023, 32'h0);
        check("rd1023", 32'hFFFFFFFF);
        cycle(0, 0, 0, 1, 10'd1, 32'h0);
        check("rd1_no_alias", 32'h0);
        cycle(0, 0, 0, 1, 10'd511, 32'h0);
        check("rd511_no_alias", 32'h0);
        cycle(0, 0, 0, 1, 10'd5, 32'h0);
        check("rd5_again", 32'hDEADBEEF);

        // Deselect ignores WE and OE.
        cycle(0, 1, 1, 0, 10'd5, 32'h12345678);
        check("deselect_wr_hold", 32'hDEADBEEF);
        cycle(0, 1, 0, 1, 10'd0, 32'h0);
        check("deselect_rd_hold", 32'hDEADBEEF);
        // Idle holds.
        cycle(0, 0, 1, 1, 10'd0, 32'h0);
        check("idle_hold", 32'hDEADBEEF);
        // Prove the deselected write never committed.
        cycle(0, 0, 0, 1, 10'd0, 32'h0);
        check("rd0_between", 32'h00000001);
        cycle(0, 0, 0, 1, 10'd5, 32'h0);
        check("rd5_not_overwritten", 32'hDEADBEEF);

        // Write wins over read when both strobes are low.
        cycle(0, 0, 0, 0, 10'd7, 32'hA5A5A5A5);
        check("wr_priority_hold", 32'hDEADBEEF);
        cycle(0, 0, 0, 1, 10'd7, 32'h0);
        check("rd7", 32'hA5A5A5A5);

        // Reset on the same edge as a write.
        cycle(0, 0, 1, 0, 10'd9, 32'h11111111);
        cycle(0, 0, 0, 1, 10'd9, 32'h0);
        check("rd9_before", 32'h11111111);
        cycle(1, 0, 1, 0, 10'd9, 32'h00000055);
        check("midreset_clear", 32'h0);
        cycle(0, 0, 0, 1, 10'd9, 32'h0);
        check("rd9_preserved", 32'h11111111);
        cycle(0, 0, 0, 1, 10'd7, 32'h0);
        check("rd7_preserved", 32'hA5A5A5A5);
        cycle(0, 0, 0, 1, 10'd1023, 32'h0);
        check("rd1023_preserved", 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stack_memory
